uart_rx: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sampler.sv | 57 +++++
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity types, default widths and legal prescale ratios.
package uart_pkg;

  localparam int unsigned DATA_WIDTH_DEF     = 8;
  localparam int unsigned PRESCALE_WIDTH_DEF = 6;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Unsupported oversampling ratios fall back to 8.
  function automatic int unsigned legal_prescale(input int unsigned p);
    return (p == PRESCALE_16 || p == PRESCALE_32) ? p : PRESCALE_8;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three mid-bit samples and a 2-of-3 majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rx_i,
  input  logic                      clear_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      vote_c_o,
  output logic                      sample_done_c_o,
  output logic                      bit_done_c_o
);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] half;
  logic                      s0_q, s0_d;
  logic                      s1_q, s1_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      s0_q  <= 1'b1;
      s1_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
    end
  end

  always_comb begin
    half            = prescale_i >> 1;
    cnt_d           = cnt_q;
    s0_d            = s0_q;
    s1_d            = s1_q;
    bit_done_c_o    = (cnt_q == prescale_i - 1'b1);
    sample_done_c_o = (cnt_q == half + 1'b1);
    // The third sample is the live input, so the vote resolves on the edge after the second.
    vote_c_o        = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);

    if (clear_i || bit_done_c_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_q == half - 1'b1) begin
      s0_d = rx_i;
    end
    if (cnt_q == half) begin
      s1_d = rx_i;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, shift register, parity/stop checks and pulse outputs.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      DATA_VLD,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
);

  localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e               state_q, state_d;
  logic [1:0]                sync_q;
  logic                      rx_s;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                      par_err_q, par_err_d;
  logic                      stp_err_q, stp_err_d;
  logic                      fin_q, fin_d;
  logic                      armed_q, armed_d;
  logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
  logic                      vld_q, vld_d;
  logic                      perr_q, perr_d;
  logic                      serr_q, serr_d;
  logic                      vote_c;
  logic                      sample_done_c;
  logic                      bit_done_c;
  logic                      clear_c;

  assign rx_s     = sync_q[1];
  assign clear_c  = (state_d == IDLE);
  assign P_DATA   = p_data_q;
  assign DATA_VLD = vld_q;
  assign PAR_ERR  = perr_q;
  assign STP_ERR  = serr_q;

  uart_rx_sampler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_sampler (
    .clk_i           (CLK),
    .rst_i           (RST),
    .rx_i            (rx_s),
    .clear_i         (clear_c),
    .prescale_i      (prescale_q),
    .vote_c_o        (vote_c),
    .sample_done_c_o (sample_done_c),
    .bit_done_c_o    (bit_done_c)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      prescale_q <= PRESCALE_WIDTH'(PRESCALE_8);
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      fin_q      <= 1'b0;
      armed_q    <= 1'b1;
      p_data_q   <= '0;
      vld_q      <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], RX_IN};
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
      fin_q      <= fin_d;
      armed_q    <= armed_d;
      p_data_q   <= p_data_d;
      vld_q      <= vld_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;
    fin_d      = 1'b0;
    armed_d    = armed_q | rx_s;
    p_data_d   = p_data_q;
    vld_d      = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;

    // Report the frame one cycle after the FSM is back in IDLE.
    if (fin_q) begin
      if (!par_err_q && !stp_err_q) begin
        p_data_d = shreg_q;
        vld_d    = 1'b1;
      end else begin
        perr_d = par_err_q;
        serr_d = stp_err_q;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s && armed_q) begin
          state_d    = START;
          prescale_d = PRESCALE_WIDTH'(legal_prescale(32'(PRESCALE)));
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          bit_cnt_d  = '0;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
        end
      end
      START: begin
        if (sample_done_c && vote_c) begin
          state_d = IDLE;
        end else if (bit_done_c) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample_done_c) begin
          shreg_d = {vote_c, shreg_q[DATA_WIDTH-1:1]};
        end
        if (bit_done_c) begin
          if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (sample_done_c) begin
          par_err_d = vote_c != ((^shreg_q) ^ (par_typ_q == PAR_ODD));
        end
        if (bit_done_c) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // A low stop bit disarms start detection until the line has been seen high.
        if (sample_done_c) begin
          stp_err_d = ~vote_c;
          if (!vote_c) begin
            armed_d = 1'b0;
          end
        end
        if (bit_done_c) begin
          state_d = IDLE;
          fin_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
